// File: rtl/mac_accumulator.sv
// Streaming signed multiply-accumulate result accumulator. Sums a group of
// signed products plus a per-group bias with symmetric saturation and emits one
// registered result per group in the converter's fixed-point input format.
module mac_accumulator #(
  parameter int unsigned IN_WIDTH  = 32,
  parameter int unsigned ACC_WIDTH = 43,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [IN_WIDTH-1:0]  product_in,
  input  logic                 product_valid,
  input  logic                 product_last,
  input  logic [ACC_WIDTH-1:0] bias_in,
  input  logic                 clear,
  output logic [ACC_WIDTH-1:0] fixed_out,
  output logic                 fixed_valid,
  output logic                 sat_flag,
  output logic [CNT_WIDTH-1:0] beat_count
);

  localparam int unsigned SumWidth = ACC_WIDTH + 1;

  // Symmetric clamp limits at the extended width: +(2^(ACC_WIDTH-1)-1) and its negation.
  localparam logic [SumWidth-1:0] MaxPos = {2'b00, {(ACC_WIDTH - 1){1'b1}}};
  localparam logic [SumWidth-1:0] MinNeg = {2'b11, {(ACC_WIDTH - 2){1'b0}}, 1'b1};

  localparam logic [CNT_WIDTH-1:0] CntOne = {{(CNT_WIDTH - 1){1'b0}}, 1'b1};

  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic                 first_q, first_d;
  logic                 run_sat_q, run_sat_d;
  logic [CNT_WIDTH-1:0] run_cnt_q, run_cnt_d;
  logic [ACC_WIDTH-1:0] fixed_out_q, fixed_out_d;
  logic                 fixed_valid_q, fixed_valid_d;
  logic                 sat_flag_q, sat_flag_d;
  logic [CNT_WIDTH-1:0] beat_count_q, beat_count_d;

  logic [SumWidth-1:0]  prod_ext;
  logic [SumWidth-1:0]  base_ext;
  logic [SumWidth-1:0]  sum;
  logic [ACC_WIDTH-1:0] sum_clamped;
  logic                 sat_now;

  // Extended-width sum of (bias or running acc) and product, then symmetric clamp.
  always_comb begin
    prod_ext = {{(SumWidth - IN_WIDTH){product_in[IN_WIDTH-1]}}, product_in};
    base_ext = first_q ? {bias_in[ACC_WIDTH-1], bias_in} : {acc_q[ACC_WIDTH-1], acc_q};
    sum      = base_ext + prod_ext;
    sat_now  = 1'b0;
    if ($signed(sum) > $signed(MaxPos)) begin
      sum_clamped = MaxPos[ACC_WIDTH-1:0];
      sat_now     = 1'b1;
    end else if ($signed(sum) < $signed(MinNeg)) begin
      sum_clamped = MinNeg[ACC_WIDTH-1:0];
      sat_now     = 1'b1;
    end else begin
      sum_clamped = sum[ACC_WIDTH-1:0];
    end
  end

  // Next-state for group state and output registers; clear overrides a valid beat.
  always_comb begin
    acc_d         = acc_q;
    first_d       = first_q;
    run_sat_d     = run_sat_q;
    run_cnt_d     = run_cnt_q;
    fixed_out_d   = fixed_out_q;
    fixed_valid_d = 1'b0;
    sat_flag_d    = sat_flag_q;
    beat_count_d  = beat_count_q;

    if (clear) begin
      first_d   = 1'b1;
      run_sat_d = 1'b0;
      run_cnt_d = '0;
    end else if (product_valid) begin
      acc_d = sum_clamped;
      if (first_q) begin
        run_cnt_d = CntOne;
        run_sat_d = sat_now;
        first_d   = 1'b0;
      end else begin
        run_cnt_d = (run_cnt_q == '1) ? run_cnt_q : run_cnt_q + CntOne;
        run_sat_d = run_sat_q | sat_now;
      end
      if (product_last) begin
        fixed_out_d   = acc_d;
        sat_flag_d    = run_sat_d;
        beat_count_d  = run_cnt_d;
        fixed_valid_d = 1'b1;
        first_d       = 1'b1;
      end
    end
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_q         <= '0;
      first_q       <= 1'b1;
      run_sat_q     <= 1'b0;
      run_cnt_q     <= '0;
      fixed_out_q   <= '0;
      fixed_valid_q <= 1'b0;
      sat_flag_q    <= 1'b0;
      beat_count_q  <= '0;
    end else begin
      acc_q         <= acc_d;
      first_q       <= first_d;
      run_sat_q     <= run_sat_d;
      run_cnt_q     <= run_cnt_d;
      fixed_out_q   <= fixed_out_d;
      fixed_valid_q <= fixed_valid_d;
      sat_flag_q    <= sat_flag_d;
      beat_count_q  <= beat_count_d;
    end
  end

  assign fixed_out   = fixed_out_q;
  assign fixed_valid = fixed_valid_q;
  assign sat_flag    = sat_flag_q;
  assign beat_count  = beat_count_q;

endmodule

// File: tb/tb_mac_accumulator.sv
// Self-checking bench for mac_accumulator: directed table, reset corner case,
// and randomized traffic against a plain-arithmetic reference model.
module tb_mac_accumulator;

  localparam longint Max = 64'sd4398046511103;  // 2^42-1

  logic        clk;
  logic        reset_n;
  logic [31:0] product_in;
  logic        product_valid;
  logic        product_last;
  logic [42:0] bias_in;
  logic        clear;
  logic [42:0] fixed_out;
  logic        fixed_valid;
  logic        sat_flag;
  logic [15:0] beat_count;

  mac_accumulator #(
    .IN_WIDTH (32),
    .ACC_WIDTH(43),
    .CNT_WIDTH(16)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .product_in   (product_in),
    .product_valid(product_valid),
    .product_last (product_last),
    .bias_in      (bias_in),
    .clear        (clear),
    .fixed_out    (fixed_out),
    .fixed_valid  (fixed_valid),
    .sat_flag     (sat_flag),
    .beat_count   (beat_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec;
  int n_err;

  // Reference model state (group view of the specification).
  longint m_acc;
  bit     m_first;
  bit     m_sat;
  int     m_cnt;
  longint m_out;
  bit     m_valid;
  bit     m_sat_o;
  int     m_cnt_o;

  typedef struct {
    bit     v;
    bit     l;
    bit     c;
    int     prod;
    longint bias;
    bit     e_valid;
    longint e_out;
    bit     e_sat;
    int     e_cnt;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit v, bit l, bit c, int prod, longint bias,
                              bit e_valid, longint e_out, bit e_sat, int e_cnt);
    vec_t r;
    r.v = v; r.l = l; r.c = c; r.prod = prod; r.bias = bias;
    r.e_valid = e_valid; r.e_out = e_out; r.e_sat = e_sat; r.e_cnt = e_cnt;
    return r;
  endfunction

  task automatic model_reset();
    m_acc = 0; m_first = 1'b1; m_sat = 1'b0; m_cnt = 0;
    m_out = 0; m_valid = 1'b0; m_sat_o = 1'b0; m_cnt_o = 0;
  endtask

  task automatic model_step(input bit v, input bit l, input bit c,
                            input int prod, input longint bias);
    longint s;
    bit     st;
    m_valid = 1'b0;
    if (c) begin
      m_first = 1'b1; m_sat = 1'b0; m_cnt = 0;
    end else if (v) begin
      s  = (m_first ? bias : m_acc) + longint'(prod);
      st = 1'b0;
      if (s > Max) begin
        s = Max; st = 1'b1;
      end else if (s < -Max) begin
        s = -Max; st = 1'b1;
      end
      m_acc = s;
      if (m_first) begin
        m_cnt = 1; m_sat = st; m_first = 1'b0;
      end else begin
        m_cnt = (m_cnt == 65535) ? 65535 : m_cnt + 1;
        m_sat = m_sat | st;
      end
      if (l) begin
        m_out = m_acc; m_sat_o = m_sat; m_cnt_o = m_cnt; m_valid = 1'b1; m_first = 1'b1;
      end
    end
  endtask

  task automatic check(input string name, input longint act, input longint exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input bit e_valid, input longint e_out,
                            input bit e_sat, input int e_cnt);
    check({tag, " fixed_valid"}, longint'(fixed_valid), longint'(e_valid));
    check({tag, " fixed_out"}, longint'($signed(fixed_out)), e_out);
    check({tag, " sat_flag"}, longint'(sat_flag), longint'(e_sat));
    check({tag, " beat_count"}, longint'(beat_count), longint'(e_cnt));
  endtask

  // Drive one cycle of inputs, advance the model, and return #1 after the edge.
  task automatic step(input bit v, input bit l, input bit c, input int prod,
                      input longint bias);
    product_valid = v;
    product_last  = l;
    clear         = c;
    product_in    = prod;
    bias_in       = bias[42:0];
    @(posedge clk);
    model_step(v, l, c, prod, bias);
    #1;
  endtask

  function automatic longint rand_bias();
    logic [42:0] t;
    case ($urandom_range(0, 3))
      0: return longint'($signed($urandom_range(0, 2000))) - 1000;
      1: return Max - longint'($urandom_range(0, 5000));
      2: return -Max + longint'($urandom_range(0, 5000));
      default: begin
        t = 43'({$urandom(), $urandom()});
        return longint'($signed(t));
      end
    endcase
  endfunction

  function automatic int rand_prod();
    case ($urandom_range(0, 3))
      0: return 32'sh7fffffff;
      1: return 32'sh80000000;
      2: return int'($urandom_range(0, 200)) - 100;
      default: return int'($urandom());
    endcase
  endfunction

  initial begin
    n_vec = 0;
    n_err = 0;
    reset_n       = 1'b0;
    product_in    = '0;
    product_valid = 1'b0;
    product_last  = 1'b0;
    bias_in       = '0;
    clear         = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    check_outs("reset", 1'b0, 0, 1'b0, 0);

    // Signed accumulate
    tbl.push_back(mk(1, 0, 0, 4, -10, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, -3, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 0, 32'sh7fffffff, 0, 1, 64'sd2147483638, 0, 3));
    // Positive saturation on beat 2, then recover by one
    tbl.push_back(mk(1, 0, 0, 8, Max - 9, 0, 64'sd2147483638, 0, 3));
    tbl.push_back(mk(1, 0, 0, 8, 0, 0, 64'sd2147483638, 0, 3));
    tbl.push_back(mk(1, 1, 0, -1, 0, 1, Max - 1, 1, 3));
    // Negative saturation, single beat
    tbl.push_back(mk(1, 1, 0, -1, -Max, 1, -Max, 1, 1));
    // Group A with an idle gap, then group B back-to-back with its own bias
    tbl.push_back(mk(1, 0, 0, 1, 100, 0, -Max, 1, 1));
    tbl.push_back(mk(0, 1, 0, 999, 777, 0, -Max, 1, 1));
    tbl.push_back(mk(1, 1, 0, 2, 555, 1, 103, 0, 2));
    tbl.push_back(mk(1, 1, 0, 5, 1000, 1, 1005, 0, 1));
    // Clear with a coincident valid beat drops the group; next group uses bias
    tbl.push_back(mk(1, 0, 0, 10, 50, 0, 1005, 0, 1));
    tbl.push_back(mk(1, 0, 0, 20, 0, 0, 1005, 0, 1));
    tbl.push_back(mk(1, 1, 1, 30, 0, 0, 1005, 0, 1));
    tbl.push_back(mk(1, 1, 0, 3, 7, 1, 10, 0, 1));
    // Consecutive single-beat groups, then idle
    tbl.push_back(mk(1, 1, 0, -3, -2, 1, -5, 0, 1));
    tbl.push_back(mk(1, 1, 0, 32'sh80000000, 0, 1, -64'sd2147483648, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, -64'sd2147483648, 0, 1));

    foreach (tbl[i]) begin
      step(tbl[i].v, tbl[i].l, tbl[i].c, tbl[i].prod, tbl[i].bias);
      check_outs($sformatf("tbl[%0d]", i), tbl[i].e_valid, tbl[i].e_out, tbl[i].e_sat,
                 tbl[i].e_cnt);
    end

    // Reset mid-group: outputs clear asynchronously, then a fresh single beat
    for (int i = 0; i < 3; i++) step(1, 0, 0, 100, 0);
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    check_outs("async reset", 1'b0, 0, 1'b0, 0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    step(1, 1, 0, 7, 5);
    check_outs("post-reset beat", 1'b1, 12, 1'b0, 1);
    step(0, 0, 0, 0, 0);
    check_outs("post-reset idle", 1'b0, 12, 1'b0, 1);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      bit v, l, c;
      v = ($urandom_range(0, 3) != 0);
      l = ($urandom_range(0, 3) == 0);
      c = ($urandom_range(0, 30) == 0);
      step(v, l, c, rand_prod(), rand_bias());
      check_outs($sformatf("rand[%0d]", i), m_valid, m_out, m_sat_o, m_cnt_o);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
